// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: per-channel programmable down-counters
// produce one-cycle ticks and 50%-duty square waves from a single system clock.
module clock_enable_gen #(
    parameter int CLK_HZ = 50000000,
    parameter int NCH    = 4,
    parameter int DIV_W  = 26,
    parameter logic [NCH*DIV_W-1:0] DIV_RST = {26'd25000000, 26'd1063830, 26'd65617, 26'd1042}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync_clr,
    input  logic               load,
    input  logic [2:0]         load_ch,
    input  logic [DIV_W-1:0]   load_div,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     sq,
    output logic [NCH-1:0]     busy
);

    // Out-of-range parameters elaborate no extra logic; the guard documents the legal range.
    if (CLK_HZ < 1 || NCH < 1 || NCH > 8) begin : g_bad_params
    end

    // Reload value for a ratio d is max(d,1)-1, so a ratio of 0 behaves like 1.
    function automatic logic [DIV_W-1:0] minus_one(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [DIV_W-1:0] RST_DIV = DIV_RST[gi*DIV_W +: DIV_W];
        localparam logic [DIV_W-1:0] RST_CNT = (RST_DIV == '0) ? '0 : RST_DIV - 1'b1;

        logic [DIV_W-1:0] div_reg, div_next;
        logic [DIV_W-1:0] cnt_reg, cnt_next;
        logic [DIV_W-1:0] pend_val_reg, pend_val_next;
        logic             pend_reg, pend_next;
        logic             tick_reg, tick_next;
        logic             sq_reg, sq_next;
        logic [DIV_W-1:0] reload_div;
        logic             load_hit;

        always_comb begin
            load_hit      = load && (load_ch == 3'(gi));
            reload_div    = pend_reg ? pend_val_reg : div_reg;
            div_next      = div_reg;
            cnt_next      = cnt_reg;
            pend_next     = pend_reg;
            pend_val_next = pend_val_reg;
            tick_next     = 1'b0;
            sq_next       = sq_reg;

            if (sync_clr) begin
                // A load arriving with the restart is applied straight away.
                if (load_hit) begin
                    reload_div = load_div;
                end
                div_next      = reload_div;
                cnt_next      = minus_one(reload_div);
                pend_next     = 1'b0;
                pend_val_next = load_hit ? load_div : pend_val_reg;
                sq_next       = 1'b0;
            end else begin
                if (en) begin
                    if (cnt_reg == '0) begin
                        tick_next = 1'b1;
                        sq_next   = ~sq_reg;
                        div_next  = reload_div;
                        cnt_next  = minus_one(reload_div);
                        pend_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                // A load coinciding with terminal count stays pending for the next one.
                if (load_hit) begin
                    pend_next     = 1'b1;
                    pend_val_next = load_div;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_reg      <= RST_DIV;
                cnt_reg      <= RST_CNT;
                pend_val_reg <= '0;
                pend_reg     <= 1'b0;
                tick_reg     <= 1'b0;
                sq_reg       <= 1'b0;
            end else begin
                div_reg      <= div_next;
                cnt_reg      <= cnt_next;
                pend_val_reg <= pend_val_next;
                pend_reg     <= pend_next;
                tick_reg     <= tick_next;
                sq_reg       <= sq_next;
            end
        end

        assign tick[gi] = tick_reg;
        assign sq[gi]   = sq_reg;
        assign busy[gi] = pend_reg;
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomized and directed bench for clock_enable_gen against an elapsed-cycle model,
// plus a default-parameter instance for the async reset / default ratio check.
module tb_clock_enable_gen;
    localparam int NCH   = 4;
    localparam int DIV_W = 8;
    localparam logic [NCH*DIV_W-1:0] SMALL_RST = {8'd5, 8'd3, 8'd2, 8'd1};
    localparam int DEF_W = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, en, sync_clr, load;
    logic [2:0]       load_ch;
    logic [DIV_W-1:0] load_div;
    logic [NCH-1:0]   tick, sq, busy;

    logic             d_rst_n, d_en, d_sync_clr, d_load;
    logic [2:0]       d_load_ch;
    logic [DEF_W-1:0] d_load_div;
    logic [3:0]       d_tick, d_sq, d_busy;

    clock_enable_gen #(.NCH(NCH), .DIV_W(DIV_W), .DIV_RST(SMALL_RST)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .load(load),
        .load_ch(load_ch), .load_div(load_div), .tick(tick), .sq(sq), .busy(busy)
    );

    clock_enable_gen u_def (
        .clk(clk), .rst_n(d_rst_n), .en(d_en), .sync_clr(d_sync_clr), .load(d_load),
        .load_ch(d_load_ch), .load_div(d_load_div), .tick(d_tick), .sq(d_sq), .busy(d_busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: count enabled cycles since the last tick/restart; tick when it reaches the ratio.
    int div_m[NCH], pend_val_m[NCH], elapsed_m[NCH];
    bit pend_m[NCH], sq_m[NCH], tick_m[NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        logic [NCH*DIV_W-1:0] r;
        r = SMALL_RST;
        for (int i = 0; i < NCH; i++) begin
            div_m[i] = int'(r[i*DIV_W +: DIV_W]);
            pend_val_m[i] = 0;
            elapsed_m[i] = 0;
            pend_m[i] = 0;
            sq_m[i] = 0;
            tick_m[i] = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit sc, input bit ld, input int ch, input int v);
        bit hit;
        int d;
        for (int i = 0; i < NCH; i++) begin
            hit = ld && (ch == i);
            tick_m[i] = 0;
            if (sc) begin
                div_m[i] = hit ? v : (pend_m[i] ? pend_val_m[i] : div_m[i]);
                pend_m[i] = 0;
                elapsed_m[i] = 0;
                sq_m[i] = 0;
            end else begin
                if (e) begin
                    d = (div_m[i] == 0) ? 1 : div_m[i];
                    elapsed_m[i]++;
                    if (elapsed_m[i] >= d) begin
                        tick_m[i] = 1;
                        sq_m[i] = !sq_m[i];
                        elapsed_m[i] = 0;
                        if (pend_m[i]) begin
                            div_m[i] = pend_val_m[i];
                            pend_m[i] = 0;
                        end
                    end
                end
                if (hit) begin
                    pend_m[i] = 1;
                    pend_val_m[i] = v;
                end
            end
        end
    endtask

    task automatic compare_outputs(input string pfx);
        logic [NCH-1:0] et, es, eb;
        for (int i = 0; i < NCH; i++) begin
            et[i] = tick_m[i];
            es[i] = sq_m[i];
            eb[i] = pend_m[i];
        end
        check({pfx, "_tick"}, 32'(tick), 32'(et));
        check({pfx, "_sq"}, 32'(sq), 32'(es));
        check({pfx, "_busy"}, 32'(busy), 32'(eb));
    endtask

    // One transaction: called at a falling edge, applies inputs across one rising edge.
    task automatic cycle(input bit e, input bit sc, input bit ld, input int ch, input int v);
        en = e;
        sync_clr = sc;
        load = ld;
        load_ch = 3'(ch);
        load_div = DIV_W'(v);
        model_step(e, sc, ld, ch, v);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        $display("cyc %0d en=%0d clr=%0d ld=%0d ch=%0d v=%0d tick=%b sq=%b busy=%b",
                 cyc, e, sc, ld, ch, v, tick, sq, busy);
        compare_outputs("cyc");
    endtask

    initial begin
        int first_t, second_t;
        rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
        d_rst_n = 1'b0; d_en = 1'b1; d_sync_clr = 1'b0; d_load = 1'b0; d_load_ch = '0; d_load_div = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_outputs("reset");
        rst_n = 1'b1;
        d_rst_n = 1'b1;

        // Ratios 1,2,3,5 free-running.
        for (int k = 0; k < 12; k++) cycle(1, 0, 0, 0, 0);
        // Ch1 to 4 via restart, then load 6 two cycles into a period.
        cycle(1, 1, 1, 1, 4);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 6);
        for (int k = 0; k < 14; k++) cycle(1, 0, 0, 0, 0);
        // Hold for 7 cycles mid-period.
        for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) cycle(1, 0, 0, 0, 0);
        // Restart with ch0=3, ch1=4 and a pending 2 on ch0.
        cycle(1, 1, 1, 0, 3);
        cycle(1, 1, 1, 1, 4);
        cycle(1, 0, 1, 0, 2);
        cycle(1, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) cycle(1, 0, 0, 0, 0);
        // Ratio 0 on ch2, then an out-of-range channel index.
        cycle(1, 0, 1, 2, 0);
        for (int k = 0; k < 10; k++) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 5, 7);
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, 0);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tick", 32'(tick), 32'd0);
        check("async_rst_sq", 32'(sq), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) cycle(1, 0, 0, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 10), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 9)));
        end

        // Default-ratio instance: async reset mid-count, then ch0 spacing.
        #2 d_rst_n = 1'b0;
        #1;
        check("def_rst_tick", 32'(d_tick), 32'd0);
        check("def_rst_sq", 32'(d_sq), 32'd0);
        check("def_rst_busy", 32'(d_busy), 32'd0);
        @(negedge clk);
        d_rst_n = 1'b1;
        first_t = -1;
        second_t = -1;
        for (int k = 1; k <= 2200 && second_t < 0; k++) begin
            @(negedge clk);
            if (d_tick[0]) begin
                if (first_t < 0) first_t = k;
                else second_t = k;
            end
        end
        $display("default ch0 ticks at %0d and %0d", first_t, second_t);
        check("def_first_tick", 32'(first_t), 32'd1042);
        check("def_spacing", 32'(second_t - first_t), 32'd1042);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
